// File: rtl/id_stage_ctrl_pkg.sv
// id_stage_ctrl_pkg: word width, RISC-V opcodes, NOP word and ID-stage state type
package id_stage_ctrl_pkg;
    localparam int WORD_WIDTH = 32;
    localparam logic [6:0] OPCODE_LOAD    = 7'h03;
    localparam logic [6:0] OPCODE_STORE   = 7'h23;
    localparam logic [6:0] OPCODE_BRANCH  = 7'h63;
    localparam logic [6:0] OPCODE_JALR    = 7'h67;
    localparam logic [6:0] OPCODE_JAL     = 7'h6f;
    localparam logic [6:0] OPCODE_COMPIMM = 7'h13;
    localparam logic [6:0] OPCODE_COMP    = 7'h33;
    localparam logic [6:0] OPCODE_LUI     = 7'h37;
    localparam logic [6:0] OPCODE_AUIPC   = 7'h17;
    localparam logic [WORD_WIDTH-1:0] NOP_ENCODING = 32'h0000_0013;
    typedef enum logic [1:0] {ID_EMPTY, ID_VALID, ID_LU_STALL} id_ctrl_state_e;
endpackage

// File: rtl/id_stage_ctrl_load_use_detect.sv
// id_stage_ctrl_load_use_detect: flags a held word that reads the register a load in EX is writing
module id_stage_ctrl_load_use_detect
    import id_stage_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_is_load,
    output logic       o_hazard
);
    logic w_rs1_used, w_rs2_used;
    assign w_rs1_used = i_opcode inside {OPCODE_COMP, OPCODE_COMPIMM, OPCODE_LOAD,
                                         OPCODE_STORE, OPCODE_BRANCH, OPCODE_JALR};
    assign w_rs2_used = i_opcode inside {OPCODE_COMP, OPCODE_STORE, OPCODE_BRANCH};
    assign o_hazard = i_ex_is_load && i_ex_rd != 5'd0 &&
                      ((w_rs1_used && i_rs1 == i_ex_rd) || (w_rs2_used && i_rs2 == i_ex_rd));
endmodule

// File: rtl/id_stage_ctrl.sv
// id_stage_ctrl: IF/ID register and bubble sequencing for the decoder
// ID_CTRL_PERF_EN adds issue and bubble performance counters
module id_stage_ctrl
    import id_stage_ctrl_pkg::*;
#(
`ifdef ID_CTRL_PERF_EN
    parameter int PERF_CNT_WIDTH = 32,
`endif
    parameter logic [WORD_WIDTH-1:0] NOP_ENCODING = id_stage_ctrl_pkg::NOP_ENCODING
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] instr_i,
    input  logic [WORD_WIDTH-1:0] pc_i,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    output logic [WORD_WIDTH-1:0] instr_o,
    output logic [WORD_WIDTH-1:0] pc_o,
    output logic                  no_op_flag_o,
    input  logic                  flush_i,
    input  logic                  ex_stall_i
`ifdef ID_CTRL_PERF_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] perf_issued_o,
    output logic [PERF_CNT_WIDTH-1:0] perf_bubbles_o
`endif
);
    id_ctrl_state_e        r_state, w_next;
    logic [WORD_WIDTH-1:0] r_instr, r_pc;
    logic [4:0]            r_ex_rd;
    logic                  r_ex_is_load;
    logic                  w_hazard, w_lu, w_issue, w_capture;

    id_stage_ctrl_load_use_detect u_lud (
        .i_opcode     (r_instr[6:0]),
        .i_rs1        (r_instr[19:15]),
        .i_rs2        (r_instr[24:20]),
        .i_ex_rd      (r_ex_rd),
        .i_ex_is_load (r_ex_is_load),
        .o_hazard     (w_hazard)
    );

    // LU_STALL has already paid its bubble, so only VALID can raise a hazard
    assign w_lu          = r_state == ID_VALID && w_hazard;
    assign w_issue       = !flush_i && !ex_stall_i && !w_lu && r_state != ID_EMPTY;
    assign no_op_flag_o  = flush_i || r_state == ID_EMPTY || w_lu;
    assign instr_ready_o = !flush_i && !ex_stall_i && !w_lu;
    assign w_capture     = instr_ready_o && instr_valid_i;
    assign instr_o       = r_instr;
    assign pc_o          = r_pc;

    always_comb begin
        w_next = r_state;
        w_next = flush_i    ? ID_EMPTY    :
                 ex_stall_i ? r_state     :
                 w_lu       ? ID_LU_STALL :
                 instr_valid_i ? ID_VALID : ID_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ID_EMPTY;
            r_instr      <= NOP_ENCODING;
            r_pc         <= '0;
            r_ex_rd      <= '0;
            r_ex_is_load <= 1'b0;
        end else begin
            r_state <= w_next;
            if (flush_i) begin
                r_instr      <= NOP_ENCODING;
                r_ex_is_load <= 1'b0;
            end else if (!ex_stall_i) begin
                r_ex_is_load <= w_issue && r_instr[6:0] == OPCODE_LOAD;
                if (w_issue)
                    r_ex_rd <= r_instr[11:7];
                if (w_capture) begin
                    r_instr <= instr_i;
                    r_pc    <= pc_i;
                end else if (!w_lu) begin
                    r_instr <= NOP_ENCODING;
                end
            end
        end
    end

`ifdef ID_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_o  <= '0;
            perf_bubbles_o <= '0;
        end else if (!ex_stall_i) begin
            if (w_issue)
                perf_issued_o <= perf_issued_o + PERF_CNT_WIDTH'(1);
            if (flush_i || w_lu)
                perf_bubbles_o <= perf_bubbles_o + PERF_CNT_WIDTH'(1);
        end
    end
`endif
endmodule

// File: tb/tb_id_stage_ctrl.sv
// tb_id_stage_ctrl: directed and random checks of id_stage_ctrl against an instruction-level model
module tb_id_stage_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] instr_i = '0, pc_i = '0;
    logic        instr_valid_i = 1'b0, flush_i = 1'b0, ex_stall_i = 1'b0;
    logic        instr_ready_o, no_op_flag_o;
    logic [31:0] instr_o, pc_o;
`ifdef ID_CTRL_PERF_EN
    logic [31:0] perf_issued_o, perf_bubbles_o;
`endif

    always #5 clk = ~clk;

    id_stage_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .pc_i(pc_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_o(instr_o), .pc_o(pc_o), .no_op_flag_o(no_op_flag_o),
        .flush_i(flush_i), .ex_stall_i(ex_stall_i)
`ifdef ID_CTRL_PERF_EN
        , .perf_issued_o(perf_issued_o), .perf_bubbles_o(perf_bubbles_o)
`endif
    );

    int n_vec = 0, n_err = 0;
    // model: one held word, whether it already took its bubble, and the last issued instruction
    bit          m_held = 0, m_bub = 0, m_ld = 0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_word = '0, m_pc = '0;
    int          m_iss = 0, m_bubs = 0;
    logic        o_noop, o_rdy;
    logic [31:0] o_instr, o_pc;
    logic [6:0]  ops [8] = '{7'h03, 7'h23, 7'h63, 7'h67, 7'h6f, 7'h13, 7'h33, 7'h37};

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic logic [31:0] gen();
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 7)]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] w, input logic [31:0] p,
                        input logic f, input logic s);
        bit hz;
        instr_valid_i = v; instr_i = w; pc_i = p; flush_i = f; ex_stall_i = s;
        @(negedge clk);
        hz = m_held && !m_bub && m_ld && m_rd != 5'd0 &&
             ((reads_rs1(m_word[6:0]) && m_word[19:15] == m_rd) ||
              (reads_rs2(m_word[6:0]) && m_word[24:20] == m_rd));
        o_noop = no_op_flag_o; o_rdy = instr_ready_o; o_instr = instr_o; o_pc = pc_o;
        chk1("no_op", o_noop, f || !m_held || hz);
        chk1("ready", o_rdy, !f && !s && !hz);
        chk("instr", o_instr, m_held ? m_word : 32'h0000_0013);
        chk("pc", o_pc, m_pc);
        if (f) begin
            m_held = 0; m_ld = 0;
            if (!s) m_bubs++;
        end else if (!s) begin
            if (hz) begin
                m_bub = 1; m_ld = 0; m_bubs++;
            end else begin
                if (m_held) begin
                    m_iss++; m_rd = m_word[11:7]; m_ld = m_word[6:0] == 7'h03;
                end else m_ld = 0;
                m_held = v;
                if (v) begin m_word = w; m_pc = p; m_bub = 0; end
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        instr_valid_i = 1'b1; instr_i = 32'h0050_0093;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_noop", no_op_flag_o, 1'b1);
        chk("rst_instr", instr_o, 32'h0000_0013);
        chk("rst_pc", pc_o, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1, 32'h0050_0093, 32'h100, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0);
        chk("t1_instr", o_instr, 32'h0050_0093);
        chk1("t1_noop", o_noop, 1'b0);
        step(1, 32'h0001_2283, 32'h200, 0, 0);
        step(1, 32'h0012_8333, 32'h204, 0, 0);
        step(1, 32'h0050_0093, 32'h208, 0, 0);
        chk1("t2_bubble", o_noop, 1'b1);
        chk1("t2_ready", o_rdy, 1'b0);
        chk("t2_held", o_instr, 32'h0012_8333);
        step(0, 32'h0, 32'h0, 0, 0);
        chk1("t2_issue", o_noop, 1'b0);
        chk("t2_instr", o_instr, 32'h0012_8333);
        step(1, 32'h0001_2003, 32'h300, 0, 0);
        step(1, 32'h0010_0333, 32'h304, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0);
        chk1("t3_nobubble", o_noop, 1'b0);
        step(1, 32'h0050_0093, 32'h400, 0, 0);
        step(1, 32'h0060_0113, 32'h404, 1, 0);
        chk1("t4_noop", o_noop, 1'b1);
        chk1("t4_ready", o_rdy, 1'b0);
        step(0, 32'h0, 32'h0, 0, 0);
        chk("t4_dropped", o_instr, 32'h0000_0013);
        step(1, 32'h0062_a023, 32'h500, 0, 0);
        step(0, 32'h0, 32'h0, 0, 1);
        chk("t5_instr", o_instr, 32'h0062_a023);
        chk("t5_pc", o_pc, 32'h500);
        chk1("t5_ready", o_rdy, 1'b0);
        step(1, 32'h0070_0193, 32'h504, 1, 1);
        chk1("t5_flush", o_noop, 1'b1);
        step(0, 32'h0, 32'h0, 0, 1);
        chk("t5_empty", o_instr, 32'h0000_0013);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, gen(), $urandom,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
`ifdef ID_CTRL_PERF_EN
        chk("perf_issued", perf_issued_o, 32'(m_iss));
        chk("perf_bubbles", perf_bubbles_o, 32'(m_bubs));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
